// File: rtl/kick_cmd_tx.sv
// kick_cmd_tx: accepts a kick strength, waits for charge, drives it for a hold window,
// then forces idle through guard and cooldown before accepting the next kick.
module kick_cmd_tx #(
  parameter int HOLD_CYCLES     = 16,
  parameter int GUARD_CYCLES    = 4,
  parameter int COOLDOWN_CYCLES = 50000,
  parameter int CHARGE_TIMEOUT  = 100000,
  parameter int CNT_W           = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [6:0] req_strength,
  output logic       req_ready,
  input  logic       charge_ok,
  output logic [6:0] kick_code,
  output logic       busy,
  output logic       done_pulse,
  output logic       err_pulse
);
  typedef enum logic [2:0] {IDLE, WAIT_CHARGE, DRIVE, GUARD, COOLDOWN} state_t;
  localparam logic [CNT_W-1:0] T_HOLD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_GUARD = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_COOL  = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_CHG   = CNT_W'(CHARGE_TIMEOUT - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, term;
  logic [6:0] str, str_n;
  logic at_term, xfer, err_n;
  always_comb begin
    term = state == WAIT_CHARGE ? T_CHG :
           state == DRIVE       ? T_HOLD :
           state == GUARD       ? T_GUARD :
           state == COOLDOWN    ? T_COOL : '0;
    at_term = cnt == term;
    xfer = req_valid && req_ready;
  end
  always_comb begin
    state_n = state;
    str_n = str;
    err_n = 1'b0;
    case (state)
      IDLE: if (xfer) begin
        str_n = req_strength;
        if (req_strength == '0) err_n = 1'b1;
        else state_n = WAIT_CHARGE;
      end
      WAIT_CHARGE: if (charge_ok) state_n = DRIVE;
                   else if (at_term) begin
                     state_n = IDLE;
                     err_n = 1'b1;
                   end
      DRIVE:    if (at_term) state_n = GUARD;
      GUARD:    if (at_term) state_n = COOLDOWN;
      COOLDOWN: if (at_term) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    // counter restarts on every state entry and holds at its terminal value
    cnt_n = state_n != state ? '0 : at_term ? cnt : cnt + CNT_W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      str        <= '0;
      kick_code  <= '0;
      req_ready  <= 1'b0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      str        <= str_n;
      kick_code  <= state_n == DRIVE ? str_n : '0;
      req_ready  <= state_n == IDLE;
      busy       <= state_n != IDLE;
      done_pulse <= state_n == DRIVE && cnt_n == T_HOLD;
      err_pulse  <= err_n;
    end
  end
endmodule

// File: tb/tb_kick_cmd_tx.sv
// tb_kick_cmd_tx: timeline-based reference model plus directed and random kick traffic.
module tb_kick_cmd_tx;
  localparam int H = 16, G = 4, C = 10, CT = 20;
  logic clk = 0, rst = 1, req_valid = 0, charge_ok = 0;
  logic [6:0] req_strength = '0;
  logic req_ready, busy, done_pulse, err_pulse;
  logic [6:0] kick_code;
  int cyc = 0, vectors = 0, errs = 0;

  kick_cmd_tx #(.HOLD_CYCLES(H), .GUARD_CYCLES(G), .COOLDOWN_CYCLES(C),
                .CHARGE_TIMEOUT(CT), .CNT_W(17)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_strength(req_strength),
    .req_ready(req_ready), .charge_ok(charge_ok), .kick_code(kick_code),
    .busy(busy), .done_pulse(done_pulse), .err_pulse(err_pulse));

  always #5 clk = ~clk;

  // model: an episode starts at the accepting edge; outputs follow from elapsed cycles
  bit ep = 0;
  int t0, d0;
  logic [6:0] cs, e_code = '0;
  logic e_rdy = 0, e_busy = 0, e_done = 0, e_err = 0;
  always @(posedge clk) begin
    cyc++;
    e_err = 0;
    if (rst) ep = 0;
    else if (!ep) begin
      if (e_rdy && req_valid) begin
        if (req_strength == 0) e_err = 1;
        else begin ep = 1; t0 = cyc; d0 = -1; cs = req_strength; end
      end
    end else if (d0 < 0) begin
      if (charge_ok) d0 = cyc;
      else if (cyc - t0 == CT) begin ep = 0; e_err = 1; end
    end else if (cyc - d0 == H + G + C) ep = 0;
    e_busy = ep;
    e_rdy = !rst && !ep;
    e_code = (ep && d0 >= 0 && cyc - d0 < H) ? cs : 7'h00;
    e_done = ep && d0 >= 0 && cyc - d0 == H - 1;
  end

  int drv_start = -1, prev_start = -1, drv_len = 0, done_cyc = -1, err_cyc = -1, rdy_rise = -1;
  logic [6:0] drv_code = '0, prev_code = '0;
  logic prev_rdy = 0;
  always @(negedge clk) if (cyc >= 1) begin
    vectors++;
    if ({kick_code, req_ready, busy, done_pulse, err_pulse} !== {e_code, e_rdy, e_busy, e_done, e_err}) begin
      errs++;
      $display("FAIL cycle %0d outputs: got code=%h rdy=%b busy=%b done=%b err=%b, want code=%h rdy=%b busy=%b done=%b err=%b",
               cyc, kick_code, req_ready, busy, done_pulse, err_pulse, e_code, e_rdy, e_busy, e_done, e_err);
    end
    if (kick_code != 0 && prev_code == 0) begin
      prev_start = drv_start; drv_start = cyc; drv_len = 0; drv_code = kick_code;
    end
    if (kick_code != 0) drv_len++;
    if (done_pulse) done_cyc = cyc;
    if (err_pulse) err_cyc = cyc;
    if (req_ready && !prev_rdy) rdy_rise = cyc;
    prev_code = kick_code;
    prev_rdy = req_ready;
  end

  task automatic cycle();
    @(posedge clk); #2;
  endtask

  task automatic pin(input string nm, input int got, input int want);
    vectors++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  int xf;
  task automatic kick(input logic [6:0] s);
    int k = 0;
    req_valid = 1; req_strength = s;
    while (!req_ready && k < 500) begin cycle(); k++; end
    pin("handshake_ready", int'(req_ready), 1);
    xf = cyc;
    cycle();
    req_valid = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int k, d, dc;
    cycle(); cycle(); cycle();
    rst = 0;
    cycle();
    pin("ready_after_reset", int'(req_ready), 1);
    pin("idle_code_after_reset", int'(kick_code), 0);
    // 1: full-strength kick with charge present
    charge_ok = 1;
    kick(7'h7F);
    run(H + G + C + 10);
    pin("s1_latency", drv_start - xf, 2);
    pin("s1_len", drv_len, H);
    pin("s1_code", int'(drv_code), 'h7F);
    pin("s1_done_pos", done_cyc - drv_start, H - 1);
    pin("s1_ready_back", rdy_rise - drv_start, H + G + C);
    // 2: zero-strength request
    kick(7'h00);
    cycle();
    pin("s2_err_pos", err_cyc - xf, 1);
    pin("s2_ready", int'(req_ready), 1);
    pin("s2_no_drive", drv_start - xf < 0 ? 1 : 0, 1);
    // 3: charge timeout, then late charge
    charge_ok = 0;
    kick(7'h55);
    run(CT + 5);
    pin("s3_timeout_err", err_cyc - xf, CT + 1);
    kick(7'h33);
    while (cyc < xf + 11) cycle();
    charge_ok = 1;
    run(H + G + C + 10);
    pin("s3_late_start", drv_start - xf, 12);
    // 4: continuously held request
    req_valid = 1; req_strength = 7'h25;
    run(3 * (H + G + C + 2) + 5);
    req_valid = 0;
    pin("s4_spacing", drv_start - prev_start, H + G + C + 2);
    pin("s4_code", int'(drv_code), 'h25);
    run(H + G + C + 5);
    // 5: reset in the middle of a drive window
    dc = done_cyc;
    kick(7'h40);
    k = 0;
    while (kick_code == 0 && k < 100) begin cycle(); k++; end
    d = cyc;
    pin("s5_drive_seen", int'(kick_code), 'h40);
    run(4);
    rst = 1;
    cycle();
    rst = 0;
    cycle();
    pin("s5_code_cleared", int'(kick_code), 0);
    pin("s5_len", drv_len, 5);
    pin("s5_no_done", done_cyc, dc);
    pin("s5_start", drv_start, d);
    kick(7'h7F);
    run(H + 5);
    pin("s5_relatency", drv_start - xf, 2);
    pin("s5_relen", drv_len, H);
    run(G + C + 5);
    // 6: strength changes while driving
    kick(7'h40);
    req_strength = 7'h01;
    run(H + G + C + 5);
    pin("s6_code", int'(drv_code), 'h40);
    pin("s6_len", drv_len, H);
    // random traffic checked by the model
    for (int seg = 0; seg < 6; seg++) begin
      int pct = seg * 20;
      for (int i = 0; i < 500; i++) begin
        req_valid = ($urandom % 3) == 0;
        req_strength = ($urandom % 8) == 0 ? 7'h00 : 7'($urandom);
        charge_ok = ($urandom % 100) < pct;
        rst = ($urandom % 400) == 0;
        cycle();
      end
    end
    rst = 0; req_valid = 0;
    run(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/kick_cmd_tx.md
Name: kick_cmd_tx

Overview:
Transmit end of the 7-bit kick command bus that the timed-kick decoder samples each clk. It accepts kick requests (strength code) from the control/comms logic through a valid/ready handshake. It waits for capacitor charge, then drives the strength code on the bus for a fixed hold window, returns the bus to idle, and enforces a cooldown before the next kick. Sits between the command parser and the kicker timing decoder, same clock domain.

Parameters:
HOLD_CYCLES, 16, cycles a nonzero code is held on kick_code (>=2, so the decoder sees at least two consecutive samples)
GUARD_CYCLES, 4, cycles of idle code (7'h00) forced after each hold window
COOLDOWN_CYCLES, 50000, cycles after the guard before a new request is accepted
CHARGE_TIMEOUT, 100000, maximum cycles to wait for charge_ok before aborting
CNT_W, 17, counter width; must hold max(HOLD,GUARD,COOLDOWN,CHARGE_TIMEOUT)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  1  kick request present
req_strength  in  7  requested strength; 7'h7F = full strength, 7'h00 = invalid
req_ready  out  1  block can accept a request this cycle
charge_ok  in  1  kicker capacitor charged (already synchronised)
kick_code  out  7  command bus to the timed-kick decoder; 7'h00 = idle
busy  out  1  high in any state other than IDLE
done_pulse  out  1  one-cycle pulse when the hold window completes
err_pulse  out  1  one-cycle pulse on charge timeout or zero-strength request

Behaviour:
- All outputs registered. Reset: state=IDLE, kick_code=7'h00, req_ready=0 in the reset cycle and 1 from the first cycle after rst falls, busy=0, done_pulse=0, err_pulse=0, counter=0.
- Handshake: a transfer occurs when req_valid && req_ready at a rising edge. req_ready=1 only in IDLE. req_strength is captured into an internal register on transfer. Later changes on req_strength are ignored.
- States:
  - IDLE: on transfer with strength==0, stay in IDLE and pulse err_pulse the next cycle. On transfer with strength!=0, go to WAIT_CHARGE and clear the counter.
  - WAIT_CHARGE: kick_code=0. If charge_ok=1, go to DRIVE and clear the counter. Otherwise count; when count reaches CHARGE_TIMEOUT-1 without charge_ok, pulse err_pulse and go to IDLE without driving.
  - DRIVE: kick_code=captured strength, held for exactly HOLD_CYCLES consecutive cycles. On the last cycle, pulse done_pulse (coincident with the final drive cycle), then go to GUARD. charge_ok falling during DRIVE does not abort.
  - GUARD: kick_code=0 for exactly GUARD_CYCLES cycles, then go to COOLDOWN.
  - COOLDOWN: kick_code=0 for COOLDOWN_CYCLES cycles, then go to IDLE.
- Latency: if charge_ok=1 at the transfer, kick_code goes nonzero 2 cycles after the transfer edge (transfer, then WAIT_CHARGE, then DRIVE).
- Minimum spacing between the starts of two drive windows is HOLD+GUARD+COOLDOWN+2 cycles.
- kick_code is never nonzero outside DRIVE. It never changes value within a drive window.
- Counters saturate at their terminal value and never wrap. A counter is cleared on every state entry.
- req_valid high outside IDLE: ignored, no queueing. The request is not lost if the requester holds valid; it transfers in the first IDLE cycle.
- rst asserted in any state, including mid-DRIVE: next cycle kick_code=0 and state=IDLE. The pending request is discarded and no done_pulse or err_pulse is generated.
- done_pulse and err_pulse are never high in the same cycle.

Test Plan:
1. rst for 3 cycles, then req_valid=1, strength=7'h7F, charge_ok=1 -> kick_code=7'h7F for exactly 16 cycles starting 2 cycles after the transfer; done_pulse on the 16th cycle; then 7'h00; req_ready returns after 4+50000 cycles.
2. strength=7'h00 request -> no drive, err_pulse one cycle, req_ready stays 1.
3. charge_ok=0 throughout (CHARGE_TIMEOUT set to 20) -> kick_code stays 0, err_pulse at cycle 20, back to IDLE. Repeat with charge_ok rising at cycle 10 -> drive starts at cycle 11.
4. Hold req_valid with strength=7'h25 continuously, COOLDOWN set to 10 -> drive windows start exactly HOLD+GUARD+COOLDOWN+2 cycles apart; code is 7'h25 every time.
5. Assert rst on drive cycle 5 -> kick_code=0 the next cycle, no done_pulse; the next request behaves as in scenario 1.
6. Change req_strength to 7'h01 during DRIVE of a 7'h40 kick -> kick_code stays 7'h40 for the whole window.
